// File: rtl/uart_rx_ip_if.sv
// rtl/uart_rx_ip_if.sv - local register bus bundle for the UART receiver peripheral
interface uart_rx_ip_if;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        wen;
    logic [3:0]  wstrb;
    logic        wready;
    logic [31:0] raddr;
    logic        ren;
    logic [31:0] rdata;
    logic        rvalid;

    modport master (
        output waddr, wdata, wen, wstrb, raddr, ren,
        input  wready, rdata, rvalid
    );

    modport slave (
        input  waddr, wdata, wen, wstrb, raddr, ren,
        output wready, rdata, rvalid
    );
endinterface

// File: rtl/uart_rx_ip.sv
// rtl/uart_rx_ip.sv - 8N1 UART receiver with byte FIFO and register interface
module uart_rx_ip #(
    parameter int CLK_FREQ   = 30000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_uart_rx,
    uart_rx_ip_if.slave   bus
);
    localparam int              AW       = $clog2(FIFO_DEPTH);
    localparam logic [15:0]     DIV_RST  = 16'(CLK_FREQ / BAUD);
    localparam logic [AW:0]     FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        s1_q, s2_q, s3_q;
    logic [1:0]  warm_q;
    logic        armed_q;
    logic        enable_q, overrun_q, frame_err_q;
    logic [15:0] div_q;
    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0] count_q;
    logic [31:0] rdata_q, rd_mux;
    logic        rvalid_q;
    logic        push, pop, ovr_set, ferr_set, full, not_empty, fall, expire, rx;
    logic [15:0] div_eff, half;
    logic        w_stat, w_ctrl, w_div;
    logic        unused_ok;

    assign rx        = s2_q;
    // Arming waits for the synchronizer to flush after reset and see a real high level,
    // so a line still low at reset release is not taken as a start edge.
    assign fall      = armed_q & s3_q & ~s2_q;
    assign div_eff   = (div_q < 16'd4) ? 16'd4 : div_q;
    assign half      = ((div_eff >> 1) == 16'd0) ? 16'd1 : (div_eff >> 1);
    assign expire    = (cnt_q == 16'd1);
    assign full      = (count_q == FULL_CNT);
    assign not_empty = (count_q != '0);
    assign pop       = bus.ren & (bus.raddr[3:2] == 2'd0) & not_empty;

    assign w_stat = bus.wen & (bus.waddr[3:2] == 2'd1) & bus.wstrb[0];
    assign w_ctrl = bus.wen & (bus.waddr[3:2] == 2'd2) & bus.wstrb[0];
    assign w_div  = bus.wen & (bus.waddr[3:2] == 2'd3);

    assign bus.wready = bus.wen;
    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;

    assign unused_ok = ^{bus.waddr[31:4], bus.waddr[1:0], bus.raddr[31:4], bus.raddr[1:0],
                         bus.wdata[31:16], bus.wstrb[3:2]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            s3_q    <= 1'b1;
            warm_q  <= 2'b00;
            armed_q <= 1'b0;
        end else begin
            s1_q    <= i_uart_rx;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            warm_q  <= {warm_q[0], 1'b1};
            armed_q <= armed_q | (warm_q[1] & s2_q);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 16'd0;
            idx_q   <= 3'd0;
            shreg_q <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shreg_d  = shreg_q;
        push     = 1'b0;
        ovr_set  = 1'b0;
        ferr_set = 1'b0;
        if (!enable_q) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fall) begin
                        state_d = START;
                        cnt_d   = half;
                    end
                end
                START: begin
                    if (expire) begin
                        if (!rx) begin
                            state_d = DATA;
                            cnt_d   = div_eff;
                            idx_d   = 3'd0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
                DATA: begin
                    if (expire) begin
                        shreg_d = {rx, shreg_q[7:1]};
                        cnt_d   = div_eff;
                        if (idx_q == 3'd7) state_d = STOP;
                        else               idx_d   = idx_q + 3'd1;
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
                STOP: begin
                    if (expire) begin
                        state_d = IDLE;
                        if (!rx)                ferr_set = 1'b1;
                        else if (!full || pop)  push     = 1'b1;
                        else                    ovr_set  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr_q] <= shreg_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
        end
    end

    // Hardware set is OR-ed after the clear so a same-cycle set wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            enable_q    <= 1'b1;
            div_q       <= DIV_RST;
        end else begin
            overrun_q   <= (overrun_q   & ~(w_stat & bus.wdata[2])) | ovr_set;
            frame_err_q <= (frame_err_q & ~(w_stat & bus.wdata[3])) | ferr_set;
            if (w_ctrl) enable_q <= bus.wdata[0];
            if (w_div && bus.wstrb[0]) div_q[7:0]  <= bus.wdata[7:0];
            if (w_div && bus.wstrb[1]) div_q[15:8] <= bus.wdata[15:8];
        end
    end

    always_comb begin
        rd_mux = 32'd0;
        case (bus.raddr[3:2])
            2'd0: rd_mux = not_empty ? {24'd0, mem[rptr_q]} : 32'd0;
            2'd1: rd_mux = {28'd0, frame_err_q, overrun_q, full, not_empty};
            2'd2: rd_mux = {31'd0, enable_q};
            2'd3: rd_mux = {16'd0, div_q};
            default: rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q  <= 32'd0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= bus.ren;
            if (bus.ren) rdata_q <= rd_mux;
        end
    end
endmodule

// File: doc/uart_rx_ip.md
# uart_rx_ip

Memory-mapped UART receiver peripheral for the FemtoRV32 SoC, the receive-side counterpart of the existing UART transmitter IP. It samples an asynchronous 8N1 serial line, assembles bytes, buffers them in a small FIFO, and exposes data, status, control and baud-divider registers on the same local bus used by the GPIO, UART-TX and I2C peripherals. The top-level `device_select` gives it its own select line, and `processor_rdata` muxes its `rdata`.

## Interface
- `CLK_FREQ`, 30000000: system clock frequency in Hz.
- `BAUD`, 115200: reset baud rate. Reset divider = `CLK_FREQ/BAUD`, truncated; 260 at the defaults.
- `FIFO_DEPTH`, 8: receive FIFO entries. Power of two, at least 2.

- `clk` input 1: system clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `i_uart_rx` input 1: serial line, idle high, asynchronous to `clk`.
- `waddr` input 32: write address. Only bits [3:2] are decoded.
- `wdata` input 32: write data.
- `wen` input 1: write strobe, one cycle per access.
- `wstrb` input 4: byte enables. Only byte lanes whose enable is set are written.
- `wready` output 1: equals `wen`. Writes always complete in one cycle.
- `raddr` input 32: read address. Only bits [3:2] are decoded.
- `ren` input 1: read strobe, one cycle per access.
- `rdata` output 32: registered read data.
- `rvalid` output 1: pulses for one cycle, one cycle after `ren`.

## Operation
- Register map, selected by addr[3:2]:
  - 0x0 DATA (RO): [7:0] = FIFO head. Reading pops the FIFO. Reading while empty returns 0 and does not pop.
  - 0x4 STATUS:
    - bit0 not_empty (RO).
    - bit1 full (RO).
    - bit2 overrun, sticky, write-1-to-clear.
    - bit3 frame_err, sticky, write-1-to-clear.
    - All other bits read 0.
  - 0x8 CTRL (RW): bit0 enable, reset value 1. Clearing enable forces the FSM to IDLE and aborts any frame in progress. FIFO contents are kept.
  - 0xC BAUD_DIV (RW): [15:0] clocks per bit, reset value `CLK_FREQ/BAUD`. Values below 4 are clamped to 4.
- Input path: 2-flop synchronizer on `i_uart_rx`, plus one more history flop for falling-edge detection.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: enable=1 and a synchronized falling edge → START. The counter loads div/2.
  - START: when the counter expires, sample the line.
    - Low → DATA, counter loads div, bit index = 0.
    - High → IDLE (false start, nothing recorded).
  - DATA: each time the counter expires, shift the sampled bit in LSB first and reload div. After bit index 7 → STOP.
  - STOP: when the counter expires, sample the line, then → IDLE.
    - High and FIFO not full: push the byte.
    - High and FIFO full: drop the byte, set overrun.
    - Low: discard the byte, set frame_err.
  - IDLE only re-arms on a new falling edge, so a line held low after a framing error never starts a frame.
- Counter: 16-bit down-counter that "expires" at 1. The div/2 load is truncated, with a minimum of 1.
- FIFO: circular buffer with read and write pointers plus a count. Both pointers wrap modulo `FIFO_DEPTH`.
  - Push and pop in the same cycle: both take effect, count is unchanged.
  - Push and pop in the same cycle while full: the push is accepted and overrun is not set.
- STATUS bits and their clears:
  - If hardware sets a sticky bit in the same cycle software writes 1 to clear it, the set wins.
  - A W1C write takes effect only when wstrb[0] is set.
- Writing BAUD_DIV mid-frame takes effect at the next counter reload.
- Reset values:
  - `rdata` = 0, `rvalid` = 0.
  - FIFO empty, overrun = 0, frame_err = 0.
  - FSM in IDLE, synchronizer flops = 1.

## Timing
- Read latency: `rdata`/`rvalid` are valid the cycle after `ren`. The DATA pop happens in the `ren` cycle.
- STATUS after a pop reflects the new count on the next read.
- Writes take effect on the clock edge where `wen` is high.
- Byte arrival: the push occurs about 2 + div/2 + 9·div cycles after the start-bit falling edge reaches `i_uart_rx`, ±1 cycle of synchronizer skew. not_empty reads 1 from the following cycle.
- Sampling point: mid-bit ±1 cycle. Tolerates ±4% baud mismatch at div ≥ 16.
- Reset asserted mid-frame:
  - The partial byte is lost and the FIFO is emptied.
  - After release, the receiver waits for a fresh falling edge. Any low level still present on the line is ignored.

## Test plan
- Default div 260: send 0x55 then 0xA3 → STATUS = 0x1. DATA reads return 0x55, then 0xA3. STATUS is then 0x0, and a further DATA read returns 0.
- Glitch: drive `i_uart_rx` low for 50 cycles, then high → no push, STATUS stays 0x0, FSM returns to IDLE.
- Frame error: send 0x3C with the stop bit driven low → STATUS bit3 = 1 and FIFO empty. Writing 0x8 to STATUS clears it to 0x0. A following valid 0x81 is received correctly.
- Overrun: send 0x01..0x09 without reading → STATUS = 0x7 (full, not_empty, overrun). Reads return 0x01..0x08 in order, and 0x09 is lost.
- Baud change: write 4 and then 16 to BAUD_DIV. With 4, send 0xF0 at 4 clk/bit → DATA reads 0xF0. With 16, send 0x0F at 16 clk/bit → DATA reads 0x0F.
- Reset and enable:
  - Assert `reset_n` during data bit 3 of a byte → FIFO empty, rdata = 0, no spurious byte after release.
  - With CTRL = 0, a full frame produces no push.
